// File: rtl/msu_seq.sv
// msu_seq: sequencer for the modular squaring unit.
//
// Takes one job packet {value, end_cnt, start_cnt} from the input stream. It then
// drives an external squaring core one request at a time until the iteration
// count reaches end_cnt. It streams the final {value, count} packet and can
// also stream periodic checkpoint packets.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   ap_start / ap_done          job start pulse / job complete pulse
//   start_xfer                  pulse on entry to the final-packet phase
//   s_axis_*                    job packet in (tkeep ignored, bytes positional)
//   m_axis_*                    result / checkpoint packets out
//                               (tuser: 1 = final, 0 = checkpoint)
//   m_axis_xfer_size_in_bytes   constant output packet size
//   sq_req_* / sq_res_*         squaring core request / result
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | waiting for ap_start
// LOAD    | accepting job packet beats
// ISSUE   | presenting value to the squaring core
// WAIT    | waiting for the core result strobe
// CHK_OUT | streaming a checkpoint packet
// FIN_OUT | streaming the final packet
// DONE    | one-cycle ap_done, back to IDLE
module msu_seq #(
  parameter int AXI_LEN  = 32,
  parameter int DAT_BITS = 128,
  parameter int T_LEN    = 64,
  parameter int CHK_LOG2 = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  start_xfer,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [AXI_LEN-1:0]    s_axis_tdata,
  input  logic [AXI_LEN/8-1:0]  s_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [AXI_LEN-1:0]    m_axis_tdata,
  output logic [AXI_LEN/8-1:0]  m_axis_tkeep,
  output logic                  m_axis_tuser,
  output logic [31:0]           m_axis_xfer_size_in_bytes,
  output logic                  sq_req_val,
  input  logic                  sq_req_rdy,
  output logic [DAT_BITS-1:0]   sq_req_dat,
  input  logic                  sq_res_val,
  input  logic [DAT_BITS-1:0]   sq_res_dat
);

  localparam int BPB        = AXI_LEN / 8;
  localparam int IN_BYTS    = (DAT_BITS + 2 * T_LEN + 7) / 8;
  localparam int IN_BEATS   = (IN_BYTS + BPB - 1) / BPB;
  localparam int OUT_BYTS   = (DAT_BITS + T_LEN + 7) / 8;
  localparam int OUT_BEATS  = (OUT_BYTS + BPB - 1) / BPB;
  localparam int LAST_REM   = OUT_BYTS % BPB;
  localparam int BUF_BITS   = IN_BEATS * AXI_LEN;
  localparam int FIELD_BITS = 2 * T_LEN + DAT_BITS;
  localparam int OPK_BITS   = OUT_BEATS * AXI_LEN;
  localparam int IB_W       = $clog2(IN_BEATS + 1);
  localparam int OB_W       = $clog2(OUT_BEATS + 1);

  localparam logic [BPB-1:0] LAST_KEEP =
    (LAST_REM == 0) ? {BPB{1'b1}} : BPB'((1 << LAST_REM) - 1);
  localparam logic [T_LEN-1:0] CHK_MASK = T_LEN'((T_LEN'(1) << CHK_LOG2) - T_LEN'(1));

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_CHK, S_FIN, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [BUF_BITS-1:0] in_buf, load_buf;
  logic [IB_W-1:0]     in_beat;
  logic [OB_W-1:0]     out_beat;
  logic [T_LEN-1:0]    cnt, end_cnt, cnt_inc;
  logic [DAT_BITS-1:0] value;
  logic [T_LEN-1:0]    ld_start, ld_end;
  logic [DAT_BITS-1:0] ld_val;
  logic [OPK_BITS-1:0] out_pkt;
  logic [AXI_LEN-1:0]  out_data;
  logic                in_hs, out_hs, out_last, chk_hit;

  logic unused_keep;
  assign unused_keep = ^s_axis_tkeep;

  // Beats past the job fields (and beats past IN_BEATS) land nowhere useful.
  generate
    if (BUF_BITS > FIELD_BITS) begin : g_tail
      logic unused_tail;
      assign unused_tail = ^in_buf[BUF_BITS-1:FIELD_BITS];
    end
  endgenerate

  assign in_hs    = s_axis_tvalid && s_axis_tready;
  assign out_hs   = m_axis_tvalid && m_axis_tready;
  assign out_last = (out_beat == OB_W'(OUT_BEATS - 1));
  assign cnt_inc  = cnt + T_LEN'(1);
  assign chk_hit  = (CHK_LOG2 != 0) && ((cnt_inc & CHK_MASK) == '0);

  // The beat on the bus merged into the buffer, so the fields are usable on
  // the tlast cycle itself. in_beat saturates at IN_BEATS; excess beats match
  // no slot and are dropped.
  always_comb begin
    load_buf = in_buf;
    for (int b = 0; b < IN_BEATS; b++) begin
      if (in_beat == IB_W'(b)) load_buf[b*AXI_LEN +: AXI_LEN] = s_axis_tdata;
    end
  end

  assign ld_start = load_buf[T_LEN-1:0];
  assign ld_end   = load_buf[2*T_LEN-1:T_LEN];
  assign ld_val   = load_buf[2*T_LEN +: DAT_BITS];

  always_comb begin
    out_pkt = '0;
    out_pkt[T_LEN-1:0] = cnt;
    out_pkt[T_LEN +: DAT_BITS] = value;
  end

  always_comb begin
    out_data = '0;
    for (int b = 0; b < OUT_BEATS; b++) begin
      if (out_beat == OB_W'(b)) out_data = out_pkt[b*AXI_LEN +: AXI_LEN];
    end
  end

  assign m_axis_tdata  = m_axis_tvalid ? out_data : '0;
  assign m_axis_tlast  = m_axis_tvalid && out_last;
  assign m_axis_tkeep  = !m_axis_tvalid ? '0 : (out_last ? LAST_KEEP : {BPB{1'b1}});
  assign m_axis_tuser  = m_axis_tvalid && (state == S_FIN);
  assign m_axis_xfer_size_in_bytes = 32'(OUT_BYTS);
  assign sq_req_dat    = value;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ap_start) state_nxt = S_LOAD;
      S_LOAD:  if (in_hs && s_axis_tlast)
                 state_nxt = (ld_start >= ld_end) ? S_FIN : S_ISSUE;
      S_ISSUE: if (sq_req_val && sq_req_rdy) state_nxt = S_WAIT;
      S_WAIT:  if (sq_res_val) begin
                 if (cnt_inc == end_cnt) state_nxt = S_FIN;
                 else if (chk_hit)       state_nxt = S_CHK;
                 else                    state_nxt = S_ISSUE;
               end
      S_CHK:   if (out_hs && out_last) state_nxt = S_ISSUE;
      S_FIN:   if (out_hs && out_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs are registered off the next state so they line up with
  // the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axis_tready <= 1'b0;
      sq_req_val    <= 1'b0;
      m_axis_tvalid <= 1'b0;
      start_xfer    <= 1'b0;
      ap_done       <= 1'b0;
      in_buf        <= '0;
      in_beat       <= '0;
      out_beat      <= '0;
      cnt           <= '0;
      end_cnt       <= '0;
      value         <= '0;
    end else begin
      s_axis_tready <= (state_nxt == S_LOAD);
      sq_req_val    <= (state_nxt == S_ISSUE);
      m_axis_tvalid <= (state_nxt == S_CHK) || (state_nxt == S_FIN);
      start_xfer    <= (state_nxt == S_FIN) && (state != S_FIN);
      ap_done       <= (state_nxt == S_DONE);

      if (state == S_IDLE && ap_start) begin
        in_buf  <= '0;
        in_beat <= '0;
      end else if (in_hs) begin
        in_buf <= load_buf;
        if (in_beat != IB_W'(IN_BEATS)) in_beat <= in_beat + 1'b1;
        if (s_axis_tlast) begin
          cnt     <= ld_start;
          end_cnt <= ld_end;
          value   <= ld_val;
        end
      end

      if (state == S_WAIT && sq_res_val) begin
        value <= sq_res_dat;
        cnt   <= cnt_inc;
      end

      if (out_hs) out_beat <= out_last ? '0 : out_beat + 1'b1;
    end
  end

endmodule

// File: tb/tb_msu_seq.sv
module tb_msu_seq;
  localparam int AXI_LEN   = 32;
  localparam int DAT_BITS  = 100;
  localparam int T_LEN     = 64;
  localparam int CHK       = 1;
  localparam int OUT_BEATS = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic ap_start, ap_done, start_xfer;
  logic s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [AXI_LEN-1:0] s_axis_tdata;
  logic [3:0] s_axis_tkeep;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [AXI_LEN-1:0] m_axis_tdata;
  logic [3:0] m_axis_tkeep;
  logic [31:0] m_axis_xfer_size_in_bytes;
  logic sq_req_val, sq_req_rdy, sq_res_val;
  logic [DAT_BITS-1:0] sq_req_dat, sq_res_dat;

  always #5 clk = ~clk;

  msu_seq #(.AXI_LEN(AXI_LEN), .DAT_BITS(DAT_BITS), .T_LEN(T_LEN), .CHK_LOG2(CHK)) dut (
    .clk(clk), .rst_n(rst_n), .ap_start(ap_start), .ap_done(ap_done), .start_xfer(start_xfer),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_xfer_size_in_bytes(m_axis_xfer_size_in_bytes),
    .sq_req_val(sq_req_val), .sq_req_rdy(sq_req_rdy), .sq_req_dat(sq_req_dat),
    .sq_res_val(sq_res_val), .sq_res_dat(sq_res_dat)
  );

  typedef struct {
    logic                tuser;
    logic [T_LEN-1:0]    cnt;
    logic [DAT_BITS-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   sx_cnt = 0;
  int   req_cycles = 0;
  int   sq_issues = 0;
  logic rnd_en = 1'b0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference sequence: square until count reaches end, checkpoint on every
  // count that is a multiple of 2^CHK, final wins over checkpoint.
  task automatic push_expect(input logic [T_LEN-1:0] st, input logic [T_LEN-1:0] en,
                             input logic [DAT_BITS-1:0] v);
    logic [T_LEN-1:0] c;
    logic [DAT_BITS-1:0] x;
    int guard;
    c = st;
    x = v;
    if (st >= en) begin
      sb.push_back('{1'b1, st, v});
    end else begin
      guard = 0;
      while (guard < 1000) begin
        x = x * x;
        c = c + 64'd1;
        guard++;
        if (c == en) begin
          sb.push_back('{1'b1, c, x});
          break;
        end else if ((c & ((64'd1 << CHK) - 64'd1)) == 64'd0) begin
          sb.push_back('{1'b0, c, x});
        end
      end
    end
  endtask

  // Squaring core: x^2 mod 2^100, result strobe three cycles after request.
  initial begin : core
    logic hs;
    logic [DAT_BITS-1:0] x;
    int delay;
    hs = 1'b0;
    x = '0;
    delay = 0;
    sq_req_rdy = 1'b0;
    sq_res_val = 1'b0;
    sq_res_dat = '0;
    forever begin
      @(negedge clk);
      hs = rst_n && sq_req_val && sq_req_rdy;
      if (hs) x = sq_req_dat;
      @(posedge clk);
      #1;
      sq_res_val = 1'b0;
      if (!rst_n) delay = 0;
      else if (hs) begin
        delay = 3;
        sq_issues++;
      end else if (delay > 0) begin
        delay--;
        if (delay == 0) begin
          sq_res_val = 1'b1;
          sq_res_dat = x * x;
        end
      end
      sq_req_rdy = (delay == 0) && !sq_res_val && (!rnd_en || ($urandom_range(0, 2) != 0));
    end
  end

  initial begin : sink
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rnd_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Output monitor: assembles packets, checks beats, pops the scoreboard.
  initial begin : mon
    int beat;
    logic [191:0] got, ep;
    logic stall_prev, done_prev, fin_last_prev;
    logic [38:0] snap;
    exp_t e;
    beat = 0;
    got = '0;
    stall_prev = 1'b0;
    done_prev = 1'b0;
    fin_last_prev = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        beat = 0;
        got = '0;
        stall_prev = 1'b0;
        done_prev = 1'b0;
        fin_last_prev = 1'b0;
        continue;
      end
      if (sq_req_val) req_cycles++;
      if (start_xfer) begin
        sx_cnt++;
        chk("start_xfer_entry", 256'({m_axis_tvalid, m_axis_tuser, beat == 0}), 256'(3'b111));
      end
      if (ap_done) begin
        done_cnt++;
        chk("ap_done_width", 256'(done_prev), 256'(0));
        chk("ap_done_after_tlast", 256'(fin_last_prev), 256'(1));
      end
      done_prev = ap_done;
      fin_last_prev = 1'b0;
      if (stall_prev)
        chk("stall_hold", 256'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata}),
            256'(snap));
      stall_prev = m_axis_tvalid && !m_axis_tready;
      snap = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (beat != 0) chk("tvalid_mid_pkt", 256'(m_axis_tvalid), 256'(1));
      if (m_axis_tvalid && m_axis_tready) begin
        chk("tkeep", 256'(m_axis_tkeep), 256'((beat == OUT_BEATS - 1) ? 4'b0001 : 4'b1111));
        chk("tlast", 256'(m_axis_tlast), 256'(beat == OUT_BEATS - 1));
        got[beat*32 +: 32] = m_axis_tdata;
        if (beat == OUT_BEATS - 1) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 256'(got), 256'(0));
          end else begin
            e = sb.pop_front();
            ep = '0;
            ep[63:0] = e.cnt;
            ep[64 +: DAT_BITS] = e.val;
            chk("pkt_data", 256'(got), 256'(ep));
            chk("pkt_tuser", 256'(m_axis_tuser), 256'(e.tuser));
          end
          fin_last_prev = m_axis_tuser;
          beat = 0;
          got = '0;
        end else begin
          beat++;
        end
      end
    end
  end

  task automatic send_job(input logic [T_LEN-1:0] st, input logic [T_LEN-1:0] en,
                          input logic [DAT_BITS-1:0] v, input int nbeats);
    logic [319:0] pkt;
    int n;
    pkt = '0;
    pkt[63:0] = st;
    pkt[127:64] = en;
    pkt[128 +: DAT_BITS] = v;
    pkt[255:228] = 28'($urandom);
    pkt[319:256] = {$urandom, $urandom};
    chk("tready_idle", 256'(s_axis_tready), 256'(0));
    ap_start = 1'b1;
    @(posedge clk);
    #1;
    ap_start = 1'b0;
    chk("tready_rise", 256'(s_axis_tready), 256'(1));
    for (int k = 0; k < nbeats; k++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = pkt[k*32 +: 32];
      s_axis_tkeep = 4'($urandom);
      s_axis_tlast = (k == nbeats - 1);
      n = 0;
      @(negedge clk);
      while (!s_axis_tready && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("in_tready", 256'(s_axis_tready), 256'(1));
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tdata = '0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("job_done", 256'(done_cnt), 256'(target));
    chk("sb_empty", 256'(sb.size()), 256'(0));
    chk("start_xfer_cnt", 256'(sx_cnt), 256'(target));
  endtask

  task automatic chk_outs_zero(input string tag);
    chk(tag, 256'({ap_done, start_xfer, s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata,
                   m_axis_tkeep, m_axis_tuser, sq_req_val, sq_req_dat}), 256'(0));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    logic [DAT_BITS-1:0] v;
    int base, n, jobs;
    rst_n = 1'b0;
    ap_start = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    jobs = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outs_zero("reset_outs");
    chk("xfer_size", 256'(m_axis_xfer_size_in_bytes), 256'(21));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // start 0, end 3, value 2: checkpoint {2,16}, final {3,256}
    push_expect(64'd0, 64'd3, 100'd2);
    send_job(64'd0, 64'd3, 100'd2, 8);
    chk("issue_latency", 256'(sq_req_val), 256'(1));
    jobs++;
    wait_done(jobs, 500);

    // start 0, end 4: checkpoint {2,16}, final {4,65536}, no checkpoint at 4
    push_expect(64'd0, 64'd4, 100'd2);
    send_job(64'd0, 64'd4, 100'd2, 8);
    jobs++;
    wait_done(jobs, 500);

    // zero iterations: start == end, then start > end
    base = req_cycles;
    push_expect(64'd5, 64'd5, 100'd7);
    send_job(64'd5, 64'd5, 100'd7, 8);
    chk("bypass_latency", 256'(m_axis_tvalid), 256'(1));
    jobs++;
    wait_done(jobs, 200);
    chk("bypass_no_req", 256'(req_cycles - base), 256'(0));

    v = {4'($urandom), $urandom, $urandom, $urandom};
    push_expect(64'd9, 64'd4, v);
    send_job(64'd9, 64'd4, v, 8);
    jobs++;
    wait_done(jobs, 200);

    // random back-pressure on the output and core request
    rnd_en = 1'b1;
    for (int j = 0; j < 2; j++) begin
      v = {4'($urandom), $urandom, $urandom, $urandom};
      push_expect(64'd3, 64'd9, v);
      send_job(64'd3, 64'd9, v, 8);
      jobs++;
      wait_done(jobs, 2000);
    end
    rnd_en = 1'b0;
    @(posedge clk);
    #1;

    // early tlast after 3 beats: end keeps low 32 bits only, value is 0
    v = {4'($urandom), $urandom, $urandom, $urandom};
    push_expect(64'd0, 64'd2, 100'd0);
    send_job(64'd0, 64'hDEAD_BEEF_0000_0002, v, 3);
    jobs++;
    wait_done(jobs, 500);

    // 10 input beats: last two are discarded
    push_expect(64'd1, 64'd3, 100'd5);
    send_job(64'd1, 64'd3, 100'd5, 10);
    jobs++;
    wait_done(jobs, 500);

    // reset while waiting on iteration 2
    base = sq_issues;
    push_expect(64'd0, 64'd6, 100'd3);
    send_job(64'd0, 64'd6, 100'd3, 8);
    n = 0;
    while (sq_issues < base + 2 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_iter2", 256'(sq_issues), 256'(base + 2));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk_outs_zero("abort_outs_now");
    repeat (2) @(negedge clk);
    chk_outs_zero("abort_outs_held");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_done", 256'(done_cnt), 256'(jobs));

    // fresh job, with ap_start pulsed while busy
    push_expect(64'd2, 64'd5, 100'd3);
    send_job(64'd2, 64'd5, 100'd3, 8);
    repeat (3) @(posedge clk);
    #1;
    ap_start = 1'b1;
    @(posedge clk);
    #1;
    ap_start = 1'b0;
    jobs++;
    wait_done(jobs, 500);
    repeat (4) @(posedge clk);
    #1;
    chk("idle_after_jobs", 256'({s_axis_tready, m_axis_tvalid, sq_req_val}), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/msu_seq.md
# msu_seq

Parametrised sequencer for the modular squaring unit. Accepts a job packet {value, end_cnt, start_cnt} over AXI-stream and drives an external squaring core through a request/response handshake for (end_cnt − start_cnt) iterations. Emits the final {value, count} packet, plus optional periodic checkpoint packets, with correct tkeep and a tuser tag. Sits between the host AXI DMA and the squaring datapath.

## Interface

- AXI_LEN, 32, stream data width in bits (multiple of 8).
- DAT_BITS, 128, squaring value width.
- T_LEN, 64, iteration counter width (multiple of 8).
- CHK_LOG2, 0, checkpoint interval 2^CHK_LOG2 iterations; 0 disables checkpoints.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ap_start  in  1  one-cycle job start pulse.
- ap_done  out  1  one-cycle pulse after the final packet completes.
- start_xfer  out  1  one-cycle pulse when the final result is ready to stream.
- s_axis_tvalid/tready/tlast  in/out/in  1  input stream handshake.
- s_axis_tdata  in  AXI_LEN  input data.
- s_axis_tkeep  in  AXI_LEN/8  ignored; bytes are positional.
- m_axis_tvalid/tready/tlast  out/in/out  1  output stream handshake.
- m_axis_tdata  out  AXI_LEN  output data.
- m_axis_tkeep  out  AXI_LEN/8  byte enables.
- m_axis_tuser  out  1  1 = final packet, 0 = checkpoint.
- m_axis_xfer_size_in_bytes  out  32  constant OUT_BYTS.
- sq_req_val/sq_req_rdy  out/in  1  core request handshake.
- sq_req_dat  out  DAT_BITS  value to square.
- sq_res_val  in  1  core result strobe; the core is never back-pressured.
- sq_res_dat  in  DAT_BITS  squared result.

## Operation

- Input packet, little-endian by byte: start_cnt, then end_cnt, then value. IN_BYTS = (DAT_BITS+2·T_LEN+7)/8.
- Output packet: count (T_LEN bits), then value. OUT_BYTS = (DAT_BITS+T_LEN+7)/8. Beats = ceil(OUT_BYTS/(AXI_LEN/8)).
- States: IDLE, LOAD, ISSUE, WAIT, CHK_OUT, FIN_OUT, DONE.
- IDLE → LOAD on ap_start. ap_start in any other state is ignored.
- LOAD: tready=1. Beat k fills bytes [k·AXI_LEN/8 …]. Bytes beyond IN_BYTS are discarded.
  - Early tlast: unfilled bytes are zero.
  - On tlast: if start_cnt ≥ end_cnt → FIN_OUT with count=start_cnt and value unchanged; else cnt=start_cnt → ISSUE.
- ISSUE: sq_req_val=1, sq_req_dat=value. On sq_req_rdy → WAIT.
- WAIT: on sq_res_val, value ← sq_res_dat and cnt ← cnt+1. Then:
  - cnt==end_cnt → FIN_OUT.
  - else if CHK_LOG2≠0 and cnt[CHK_LOG2-1:0]==0 → CHK_OUT.
  - else → ISSUE.
  - Final takes priority over checkpoint.
- CHK_OUT: stream {cnt, value} with tuser=0; squaring paused; after last beat → ISSUE.
- FIN_OUT: start_xfer pulses on the entry cycle. Stream {cnt, value} with tuser=1. After the last-beat handshake → DONE.
- DONE: ap_done=1 for one cycle → IDLE.
- tkeep: all ones on every beat except the last. The last beat has the low (OUT_BYTS mod AXI_LEN/8) bits set, or all ones if that remainder is 0. Unused last-beat tdata bytes are zero.
- cnt arithmetic is modulo 2^T_LEN. end_cnt < start_cnt is treated as zero iterations.

## Timing

- Reset: all outputs 0, state IDLE, all registers cleared. Assertion mid-job aborts immediately, with no partial packet completion.
- tready rises the cycle after ap_start is sampled.
- ISSUE is entered the cycle after the input tlast handshake. sq_req_val is registered.
- After the sq_res_val cycle, the next sq_req_val (or first m_axis_tvalid) is asserted one cycle later.
- m_axis tdata, tkeep, tlast and tuser hold stable while tvalid && !tready. tvalid does not drop mid-packet. Beats may go back-to-back at one per cycle.
- ap_done asserts the cycle after the final tlast handshake.
- Bypass latency (zero iterations, tready held high): first output beat 1 cycle after input tlast.

## Test plan

- DAT_BITS=100, T_LEN=64, AXI_LEN=32; bench core returns x² mod 2^100 after 3 cycles. Job start=0, end=3, value=2 → 8 input beats; output is 6 beats with {count=3, value=256}, last tkeep=4'b0001, tuser=1; start_xfer then ap_done each pulse once.
- Same setup, CHK_LOG2=1, start=0, end=4, value=2 → checkpoint {2, 16} with tuser=0, then final {4, 65536} with tuser=1; no checkpoint at count 4.
- start=5, end=5, value=7 → no sq_req_val; output {5, 7}, tuser=1.
- Random m_axis_tready (50%) and sq_req_rdy stalls → identical data; tdata stable during every stall.
- Early tlast after 3 input beats → value=0 and end_cnt's upper half zero; job runs with the padded fields. Input of 10 beats → beats 9–10 accepted and discarded.
- rst_n asserted during WAIT of iteration 2, then a fresh job → all outputs 0 during reset; second job result is correct; ap_start during the busy phase is ignored.
